dram: RTL and testbench

Behavioural, cycle-based model of a 32-bit-wide DRAM with a multiplexed row/column address bus. It is controlled by the RASn/CASn strobes and has per-byte write enables. It sits on the memory side of the accelerator datapath as the off-chip feature/weight store. Its contents are preloaded and inspected hierarchically through four byte-lane arrays.

---
 rtl/dram.sv | 122 ++++++++++++
 tb/tb_dram.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dram.sv
// dram: cycle-based model of a 32-bit DRAM with a multiplexed row/column
// address bus, RASn/CASn strobes and per-byte write enables. Storage is
// four byte-lane arrays (Memory_byte0..3) so a bench can preload and
// inspect them by hierarchical name.
module dram #(
  parameter int word_size = 32,
  parameter int addr_size = 12,
  parameter int COL_BITS  = 10
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 CSn,
  input  logic [3:0]           WEn,
  input  logic                 RASn,
  input  logic                 CASn,
  input  logic [addr_size-1:0] A,
  input  logic [word_size-1:0] D,
  output logic [word_size-1:0] Q
);

  localparam int IDX_W = addr_size + COL_BITS;
  localparam int DEPTH = 1 << IDX_W;

  // Row state: IDLE means no row latched, ACTIVE means row_reg is open.
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Byte-lane storage; lane i holds bits [8i+7:8i] of each word.
  logic [7:0] Memory_byte0 [0:DEPTH-1];
  logic [7:0] Memory_byte1 [0:DEPTH-1];
  logic [7:0] Memory_byte2 [0:DEPTH-1];
  logic [7:0] Memory_byte3 [0:DEPTH-1];

  logic [0:0]           state;
  logic                 row_open;
  logic [addr_size-1:0] row_reg;
  logic [COL_BITS-1:0]  col;
  logic [IDX_W-1:0]     idx;

  logic open_cmd;
  logic close_cmd;
  logic access;
  logic read_cmd;
  logic [3:0] lane_wr;

  assign row_open = (state == ST_ACTIVE);
  assign col      = A[COL_BITS-1:0];
  assign idx      = {row_reg, col};

  // Decode the strobes into commands; reset (RST low) suppresses all of them.
  always_comb begin
    open_cmd  = 1'b0;
    close_cmd = 1'b0;
    access    = 1'b0;
    read_cmd  = 1'b0;
    lane_wr   = 4'b0000;
    if (RST) begin
      if (!row_open) begin
        open_cmd = !CSn && !RASn;
      end else if (RASn) begin
        close_cmd = 1'b1;
      end else begin
        access = !CSn && !CASn;
      end
      read_cmd = access && (WEn == 4'b1111);
      for (int i = 0; i < 4; i++) begin
        lane_wr[i] = access && !WEn[i];
      end
    end
  end

  // Row state machine: open latches the row address, RASn high precharges.
  always_ff @(posedge CK) begin
    if (!RST) begin
      state   <= ST_IDLE;
      row_reg <= '0;
    end else if (open_cmd) begin
      state   <= ST_ACTIVE;
      row_reg <= A;
    end else if (close_cmd) begin
      state   <= ST_IDLE;
    end
  end

  // Read register: captures the full word only on an all-lanes-disabled access.
  always_ff @(posedge CK) begin
    if (!RST) begin
      Q <= '0;
    end else if (read_cmd) begin
      Q <= {Memory_byte3[idx], Memory_byte2[idx], Memory_byte1[idx], Memory_byte0[idx]};
    end
  end

  // Lane 0 write; contents survive reset.
  always_ff @(posedge CK) begin
    if (lane_wr[0]) begin
      Memory_byte0[idx] <= D[7:0];
    end
  end

  // Lane 1 write; contents survive reset.
  always_ff @(posedge CK) begin
    if (lane_wr[1]) begin
      Memory_byte1[idx] <= D[15:8];
    end
  end

  // Lane 2 write; contents survive reset.
  always_ff @(posedge CK) begin
    if (lane_wr[2]) begin
      Memory_byte2[idx] <= D[23:16];
    end
  end

  // Lane 3 write; contents survive reset.
  always_ff @(posedge CK) begin
    if (lane_wr[3]) begin
      Memory_byte3[idx] <= D[31:24];
    end
  end

endmodule

// File: tb/tb_dram.sv
// tb_dram: directed stimulus against dram with a behavioural reference model
// (row state, Q and a sparse word memory) checked every cycle, plus literal
// expectations for the documented scenarios.
module tb_dram;

  typedef logic [21:0] idx_t;

  logic        CK;
  logic        RST;
  logic        CSn;
  logic [3:0]  WEn;
  logic        RASn;
  logic        CASn;
  logic [11:0] A;
  logic [31:0] D;
  logic [31:0] Q;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  bit          m_open;
  int          m_row;
  logic [31:0] m_q;
  logic [31:0] mem_model [idx_t];

  dram #(.word_size(32), .addr_size(12), .COL_BITS(10)) dut (
    .CK(CK), .RST(RST), .CSn(CSn), .WEn(WEn), .RASn(RASn), .CASn(CASn),
    .A(A), .D(D), .Q(Q)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input idx_t i);
    return {dut.Memory_byte3[i], dut.Memory_byte2[i], dut.Memory_byte1[i], dut.Memory_byte0[i]};
  endfunction

  task automatic preload(input idx_t i, input logic [31:0] v);
    dut.Memory_byte0[i] = v[7:0];
    dut.Memory_byte1[i] = v[15:8];
    dut.Memory_byte2[i] = v[23:16];
    dut.Memory_byte3[i] = v[31:24];
    mem_model[i] = v;
  endtask

  // Behavioural view of one clock edge using the currently driven inputs
  task automatic model_edge();
    int          w_idx;
    logic [31:0] w;
    if (!RST) begin
      m_q = 32'h0; m_open = 1'b0; m_row = 0;
    end else if (!m_open) begin
      if (!CSn && !RASn) begin
        m_row = int'(A); m_open = 1'b1;
      end
    end else if (RASn) begin
      m_open = 1'b0;
    end else if (!CSn && !CASn) begin
      w_idx = m_row * 1024 + (int'(A) % 1024);
      if (WEn == 4'b1111) begin
        m_q = mem_model.exists(idx_t'(w_idx)) ? mem_model[idx_t'(w_idx)] : 32'h0;
      end else begin
        w = mem_model.exists(idx_t'(w_idx)) ? mem_model[idx_t'(w_idx)] : 32'h0;
        for (int l = 0; l < 4; l++)
          if (!WEn[l]) w[8*l +: 8] = D[8*l +: 8];
        mem_model[idx_t'(w_idx)] = w;
      end
    end
  endtask

  task automatic apply_stimulus(input bit rst, input bit csn, input logic [3:0] wen,
                                input bit rasn, input bit casn, input logic [11:0] a,
                                input logic [31:0] d);
    RST = rst; CSn = csn; WEn = wen; RASn = rasn; CASn = casn; A = a; D = d;
    @(posedge CK);
    model_edge();
    #1;
  endtask

  task automatic check_mem();
    foreach (mem_model[k]) check_output($sformatf("mem[%0d]", k), rd_word(k), mem_model[k]);
  endtask

  // Every-cycle comparison of Q against the model, away from the active edge
  always @(negedge CK) begin
    if (cmp_en) check_output("q_model", Q, m_q);
  end

  initial begin
    RST = 1'b0; CSn = 1'b1; WEn = 4'hF; RASn = 1'b1; CASn = 1'b1; A = '0; D = '0;
    m_open = 1'b0; m_row = 0; m_q = 32'h0;

    preload(22'd0,    32'h11223344);
    preload(22'd5120, 32'hDEADBEEF);
    preload(22'd5125, 32'h5A5A5A5A);
    preload(22'd5130, 32'h01010101);
    preload(22'd5131, 32'h02020202);
    preload(22'd5132, 32'h0BAD0BAD);
    for (int i = 0; i < 20; i++)
      preload(idx_t'(7*1024 + 100 + i), 32'h70000000 + i * 32'h01030507);

    // Reset with random strobes
    for (int i = 0; i < 2; i++)
      apply_stimulus(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                     12'($urandom), $urandom);
    check_output("reset_q", Q, 32'h0);
    check_mem();
    cmp_en = 1'b1;

    // Page write to row 5, columns 10 and 11
    apply_stimulus(1, 0, 4'hF, 0, 1, 12'd5,  32'h0);
    apply_stimulus(1, 0, 4'h0, 0, 0, 12'd10, 32'd10);
    apply_stimulus(1, 0, 4'h0, 0, 0, 12'd11, 32'd11);
    apply_stimulus(1, 0, 4'hF, 1, 1, 12'd0,  32'h0);
    check_output("pw_5130", rd_word(22'd5130), 32'h0000000A);
    check_output("pw_5131", rd_word(22'd5131), 32'h0000000B);
    check_output("pw_5120", rd_word(22'd5120), 32'hDEADBEEF);

    // Page read of the same columns
    apply_stimulus(1, 0, 4'hF, 0, 1, 12'd5,  32'h0);
    apply_stimulus(1, 0, 4'hF, 0, 0, 12'd10, 32'h0);
    check_output("pr_q10", Q, 32'h0000000A);
    apply_stimulus(1, 0, 4'hF, 0, 0, 12'd11, 32'h0);
    check_output("pr_q11", Q, 32'h0000000B);
    apply_stimulus(1, 0, 4'hF, 1, 1, 12'd0,  32'h0);

    // Byte lanes on word 0
    apply_stimulus(1, 0, 4'hF, 0, 1, 12'd0, 32'h0);
    apply_stimulus(1, 0, 4'hF, 0, 0, 12'd0, 32'h0);
    check_output("bl_read", Q, 32'h11223344);
    apply_stimulus(1, 0, 4'b1010, 0, 0, 12'd0, 32'hAABBCCDD);
    check_output("bl_q_hold", Q, 32'h11223344);
    check_output("bl_word0", rd_word(22'd0), 32'h11BB33DD);
    apply_stimulus(1, 0, 4'hF, 1, 1, 12'd0, 32'h0);

    // CSn high blocks open and access
    apply_stimulus(1, 1, 4'hF, 0, 1, 12'd5,  32'h0);
    apply_stimulus(1, 1, 4'h0, 0, 0, 12'd10, 32'hFFFFFFFF);
    apply_stimulus(1, 1, 4'hF, 1, 1, 12'd0,  32'h0);
    check_output("cs_5130", rd_word(22'd5130), 32'h0000000A);
    // CSn high on an open row: no access, but RASn high still closes
    apply_stimulus(1, 0, 4'hF, 0, 1, 12'd5,  32'h0);
    apply_stimulus(1, 1, 4'h0, 0, 0, 12'd12, 32'hFFFFFFFF);
    apply_stimulus(1, 1, 4'hF, 1, 1, 12'd0,  32'h0);
    check_output("cs_5132", rd_word(22'd5132), 32'h0BAD0BAD);

    // CAS before RAS ignored, then RAS/CAS together only opens the row
    apply_stimulus(1, 0, 4'h0, 1, 0, 12'd10, 32'h77777777);
    apply_stimulus(1, 0, 4'h0, 0, 0, 12'd5,  32'h00000055);
    check_output("cbr_5125", rd_word(22'd5125), 32'h5A5A5A5A);
    apply_stimulus(1, 0, 4'h0, 0, 0, 12'd12, 32'h00001234);
    check_output("rc_5132", rd_word(22'd5132), 32'h00001234);
    apply_stimulus(1, 0, 4'hF, 1, 0, 12'd13, 32'h0);

    // Read-after-write and ignored upper column bits
    apply_stimulus(1, 0, 4'hF, 0, 1, 12'd5,     32'h0);
    apply_stimulus(1, 0, 4'h0, 0, 0, 12'd20,    32'hCAFEF00D);
    apply_stimulus(1, 0, 4'hF, 0, 0, 12'd20,    32'h0);
    check_output("raw_q", Q, 32'hCAFEF00D);
    apply_stimulus(1, 0, 4'hF, 0, 0, 12'hC0A,   32'h0);
    check_output("upper_col_q", Q, 32'h0000000A);

    // Reset mid-burst aborts and closes the row
    apply_stimulus(0, 0, 4'hF, 0, 0, 12'd11, 32'h0);
    check_output("rst_mid_q", Q, 32'h0);
    apply_stimulus(1, 0, 4'hF, 0, 0, 12'd11, 32'h0);
    check_output("rst_reopen_q", Q, 32'h0);
    apply_stimulus(1, 0, 4'hF, 1, 1, 12'd0, 32'h0);

    // Page-mode read of 20 preloaded words in row 7
    apply_stimulus(1, 0, 4'hF, 0, 1, 12'd7, 32'h0);
    for (int i = 0; i < 20; i++)
      apply_stimulus(1, 0, 4'hF, 0, 0, 12'(100 + i), 32'h0);
    check_output("preload_last", Q, 32'h70000000 + 19 * 32'h01030507);
    apply_stimulus(1, 0, 4'hF, 1, 1, 12'd0, 32'h0);

    check_mem();
    @(negedge CK);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
